// File: rtl/miner_pkg.sv
// Types, constants and helpers shared by the miner search engines and the nonce verifier.
// Covers the message format, SHA-256 round constants and the difficulty target.
package miner_pkg;

  localparam int MSG_SIZE    = 40;
  localparam int PADDED_SIZE = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_START,
    ST_WAIT,
    ST_COMPARE,
    ST_RESP
  } verify_state_t;

  localparam logic [255:0] SHA_H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] SHA_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // A higher difficulty byte shifts more ones out of the target: 0 accepts any hash.
  function automatic logic [255:0] difficulty_target(input logic [7:0] difficulty);
    logic [255:0] target;
    target = '1;
    return target >> difficulty;
  endfunction

endpackage

// File: rtl/sha_256.sv
// Single-block SHA-256 core: one round per enabled cycle, done held until reset.
module sha_256 #(
  parameter int MSG_SIZE    = 40,
  parameter int PADDED_SIZE = 512
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [MSG_SIZE-1:0] message,
  output logic                done,
  output logic [255:0]        hashed
);

  localparam logic [255:0] H0 = miner_pkg::SHA_H0;

  logic [PADDED_SIZE-1:0] block;
  logic                   running;
  logic [5:0]             round;
  logic [31:0]            a, b, c, d, e, f, g, h;
  logic [31:0]            w_win [16];
  logic [31:0]            t1, t2, new_a, new_e, w_next;

  assign block = {message, 1'b1, {(PADDED_SIZE - MSG_SIZE - 65){1'b0}}, 64'(MSG_SIZE)};

  // w_win[0] is the schedule word for the current round; w_next extends the window.
  always_comb begin
    t1 = h + miner_pkg::big_sigma1(e) + ((e & f) ^ (~e & g)) + miner_pkg::SHA_K[round] + w_win[0];
    t2 = miner_pkg::big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
    new_a  = t1 + t2;
    new_e  = d + t1;
    w_next = miner_pkg::small_sigma1(w_win[14]) + w_win[9] + miner_pkg::small_sigma0(w_win[1]) + w_win[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      done    <= 1'b0;
      round   <= '0;
      hashed  <= '0;
    end else if (enable) begin
      if (!running && !done) begin
        for (int i = 0; i < 16; i++) begin
          w_win[i] <= block[PADDED_SIZE-1-32*i -: 32];
        end
        {a, b, c, d, e, f, g, h} <= H0;
        round   <= '0;
        running <= 1'b1;
      end else if (running) begin
        for (int i = 0; i < 15; i++) begin
          w_win[i] <= w_win[i+1];
        end
        w_win[15] <= w_next;
        {a, b, c, d, e, f, g, h} <= {new_a, a, b, c, new_e, e, f, g};
        round <= round + 1'b1;
        if (round == 6'd63) begin
          running <= 1'b0;
          done    <= 1'b1;
          hashed  <= {H0[255:224] + new_a, H0[223:192] + a, H0[191:160] + b, H0[159:128] + c,
                      H0[127:96] + new_e, H0[95:64] + e, H0[63:32] + f, H0[31:0] + g};
        end
      end
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and fall-through head read.
module sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nonce_verifier.sv
// Queues claimed golden nonces, re-hashes each on a private SHA-256 core and
// returns an in-order pass/fail/timeout verdict over a valid/ready handshake.
module nonce_verifier
  import miner_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sub_valid,
  output logic         sub_ready,
  input  logic [7:0]   sub_data,
  input  logic [31:0]  sub_nonce,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_pass,
  output logic         res_timeout,
  output logic [7:0]   res_data,
  output logic [31:0]  res_nonce,
  output logic [255:0] res_hash,
  output logic         busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  verify_state_t              state;
  logic [MSG_SIZE-1:0]        job_msg;
  logic [MSG_SIZE-1:0]        fifo_head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                       fifo_push;
  logic                       fifo_pop;
  logic [TW-1:0]              timer;
  logic                       core_rst;
  logic                       core_enable;
  logic                       core_done;
  logic [255:0]               core_hash;

  assign sub_ready   = !fifo_full;
  assign fifo_push   = sub_valid && !fifo_full;
  assign fifo_pop    = (state == ST_IDLE) && !fifo_empty;
  assign busy        = (fifo_count != '0) || (state != ST_IDLE);
  assign core_rst    = rst || (state == ST_CLEAR);
  assign core_enable = (state == ST_START) || (state == ST_WAIT);

  sync_fifo #(
    .WIDTH (MSG_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({sub_data, sub_nonce}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  sha_256 #(
    .MSG_SIZE    (MSG_SIZE),
    .PADDED_SIZE (PADDED_SIZE)
  ) u_sha (
    .clk     (clk),
    .rst     (core_rst),
    .enable  (core_enable),
    .message (job_msg),
    .done    (core_done),
    .hashed  (core_hash)
  );

  // Job sequencing; the core is re-armed by a one-cycle CLEAR before every job.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      job_msg     <= '0;
      timer       <= '0;
      res_valid   <= 1'b0;
      res_pass    <= 1'b0;
      res_timeout <= 1'b0;
      res_data    <= '0;
      res_nonce   <= '0;
      res_hash    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            job_msg <= fifo_head;
            state   <= ST_CLEAR;
          end
        end
        ST_CLEAR: state <= ST_START;
        ST_START: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          timer <= timer + 1'b1;
          if (core_done) begin
            state <= ST_COMPARE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            res_valid   <= 1'b1;
            res_pass    <= 1'b0;
            res_timeout <= 1'b1;
            res_data    <= job_msg[MSG_SIZE-1 -: 8];
            res_nonce   <= job_msg[31:0];
            res_hash    <= '0;
            state       <= ST_RESP;
          end
        end
        ST_COMPARE: begin
          res_valid   <= 1'b1;
          res_pass    <= (core_hash <= difficulty_target(job_msg[MSG_SIZE-1 -: 8]));
          res_timeout <= 1'b0;
          res_data    <= job_msg[MSG_SIZE-1 -: 8];
          res_nonce   <= job_msg[31:0];
          res_hash    <= core_hash;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
